// File: rtl/uart_sched_pkg.sv
// Shared types and sizing helpers for the UART transmit scheduler.
// No logic, no latency, no flow control of its own.
package uart_sched_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, GUARD} sched_state_t;

  function automatic int cnt_width(input int frame_clks);
    return (frame_clks > 2) ? $clog2(frame_clks) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
// Zero latency; no backpressure, the parent decides when to act on the grant.
module rr_arbiter import uart_sched_pkg::*; #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [DATA_W*NUM_REQ-1:0]  req_data,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       gnt_any,
  output logic [NUM_REQ-1:0]         gnt_onehot,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic [DATA_W-1:0]          gnt_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_any    = 1'b0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    gnt_data   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_any && gnt_idx == IDX_W'(k)) begin
        gnt_onehot[k] = 1'b1;
        gnt_data      = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte producers, round-robin, one frame at a time.
// byte_ready 1 cycle and t_byte 2 cycles after a request seen in IDLE; requesters wait (hold valid) until acked.
module uart_tx_scheduler import uart_sched_pkg::*; #(
  parameter int NUM_REQ    = 4,
  parameter int FRAME_CLKS = 10416,
  parameter int GUARD_CLKS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [DATA_W*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ack,
  output logic [DATA_W-1:0]           data_out,
  output logic                        byte_ready,
  output logic                        t_byte,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(FRAME_CLKS);
  localparam int GRD_W = 4;

  sched_state_t     state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] frame_cnt;
  logic [GRD_W-1:0] guard_cnt;

  logic               gnt_any;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [IDX_W-1:0]   gnt_idx;
  logic [DATA_W-1:0]  gnt_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_valid  (req_valid),
    .req_data   (req_data),
    .ptr        (ptr),
    .gnt_any    (gnt_any),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_data   (gnt_data)
  );

  assign busy = (state != IDLE);

  // Strobes are registered one state early so they are high exactly during LOAD/START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      req_ack    <= '0;
      data_out   <= '0;
      byte_ready <= 1'b0;
      t_byte     <= 1'b0;
      grant_id   <= '0;
      frame_cnt  <= '0;
      guard_cnt  <= '0;
    end else begin
      req_ack    <= '0;
      byte_ready <= 1'b0;
      t_byte     <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            data_out   <= gnt_data;
            grant_id   <= gnt_idx;
            req_ack    <= gnt_onehot;
            byte_ready <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          t_byte <= 1'b1;
          ptr    <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          state  <= START;
        end
        START: begin
          frame_cnt <= CNT_W'(FRAME_CLKS - 1);
          state     <= WAIT;
        end
        WAIT: begin
          // START is the first frame clock, so WAIT lasts FRAME_CLKS-1 cycles.
          frame_cnt <= frame_cnt - 1'b1;
          if (frame_cnt == CNT_W'(1)) begin
            if (GUARD_CLKS == 0) begin
              state <= IDLE;
            end else begin
              guard_cnt <= GRD_W'(GUARD_CLKS - 1);
              state     <= GUARD;
            end
          end
        end
        GUARD: begin
          if (guard_cnt == '0) state <= IDLE;
          else                 guard_cnt <= guard_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus a randomized run against a frame-level model.
module tb_uart_tx_scheduler;

  localparam int F  = 20;
  localparam int G  = 2;
  localparam int F0 = 8;
  localparam int G0 = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_valid0;
  logic [31:0] req_data, req_data0;
  logic [3:0]  req_ack, req_ack0;
  logic [7:0]  data_out, data_out0;
  logic        byte_ready, byte_ready0, t_byte, t_byte0, busy, busy0;
  logic [1:0]  grant_id, grant_id0;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  uart_tx_scheduler #(.NUM_REQ(4), .FRAME_CLKS(F), .GUARD_CLKS(G)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .data_out(data_out), .byte_ready(byte_ready),
    .t_byte(t_byte), .busy(busy), .grant_id(grant_id)
  );

  uart_tx_scheduler #(.NUM_REQ(4), .FRAME_CLKS(F0), .GUARD_CLKS(G0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_data(req_data0),
    .req_ack(req_ack0), .data_out(data_out0), .byte_ready(byte_ready0),
    .t_byte(t_byte0), .busy(busy0), .grant_id(grant_id0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; req_data = '0; req_valid0 = '0; req_data0 = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_data = '0; req_valid0 = '0; req_data0 = '0;
    tick();
    tick();
    total++; if (req_ack !== 4'b0)    $display("FAIL reset_ack got %b exp 0000", req_ack); else passed++;
    total++; if (data_out !== 8'h00)  $display("FAIL reset_data got %h exp 00", data_out); else passed++;
    total++; if (byte_ready !== 1'b0) $display("FAIL reset_byte_ready got %b exp 0", byte_ready); else passed++;
    total++; if (t_byte !== 1'b0)     $display("FAIL reset_t_byte got %b exp 0", t_byte); else passed++;
    total++; if (busy !== 1'b0)       $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    total++; if (grant_id !== 2'd0)   $display("FAIL reset_grant got %0d exp 0", grant_id); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req_data  = 32'h00A5_0000;
    req_valid = 4'b0100;
    tick();
    total++; if (byte_ready !== 1'b1)  $display("FAIL single_byte_ready got %b exp 1", byte_ready); else passed++;
    total++; if (data_out !== 8'hA5)   $display("FAIL single_data got %h exp a5", data_out); else passed++;
    total++; if (req_ack !== 4'b0100)  $display("FAIL single_ack got %b exp 0100", req_ack); else passed++;
    total++; if (grant_id !== 2'd2)    $display("FAIL single_grant got %0d exp 2", grant_id); else passed++;
    total++; if (t_byte !== 1'b0)      $display("FAIL single_t_byte_early got %b exp 0", t_byte); else passed++;
    req_valid = 4'b0000;
    tick();
    total++; if (t_byte !== 1'b1)      $display("FAIL single_t_byte got %b exp 1", t_byte); else passed++;
    total++; if (byte_ready !== 1'b0)  $display("FAIL single_byte_ready_late got %b exp 0", byte_ready); else passed++;
    total++; if (req_ack !== 4'b0000)  $display("FAIL single_ack_late got %b exp 0000", req_ack); else passed++;
    repeat (F + G - 1) tick();
    total++; if (busy !== 1'b1)        $display("FAIL single_busy_end got %b exp 1", busy); else passed++;
    tick();
    total++; if (busy !== 1'b0)        $display("FAIL single_idle got %b exp 0", busy); else passed++;
  endtask

  task automatic test_round_robin();
    int t0, target;
    logic [7:0] exp_d;
    do_reset();
    req_data  = 32'h1312_1110;
    req_valid = 4'hF;
    t0 = cyc;
    for (int k = 0; k < 5; k++) begin
      target = t0 + 2 + (F + G + 2) * k;
      while (cyc < target - 1) tick();
      total++; if (t_byte !== 1'b0) $display("FAIL rr_t_byte_before[%0d] got %b exp 0", k, t_byte); else passed++;
      tick();
      exp_d = 8'h10 + 8'(k % 4);
      total++; if (t_byte !== 1'b1)            $display("FAIL rr_t_byte[%0d] got %b exp 1", k, t_byte); else passed++;
      total++; if (data_out !== exp_d)         $display("FAIL rr_data[%0d] got %h exp %h", k, data_out, exp_d); else passed++;
      total++; if (grant_id !== 2'(k % 4))     $display("FAIL rr_grant[%0d] got %0d exp %0d", k, grant_id, k % 4); else passed++;
    end
    req_valid = 4'h0;
  endtask

  task automatic test_late_request();
    int t0, bad;
    do_reset();
    req_data  = 32'h3C00_0000;
    req_valid = 4'b1000;
    t0 = cyc;
    tick();
    total++; if (req_ack !== 4'b1000) $display("FAIL late_first_ack got %b exp 1000", req_ack); else passed++;
    total++; if (grant_id !== 2'd3)   $display("FAIL late_first_grant got %0d exp 3", grant_id); else passed++;
    tick();
    req_valid = 4'b0000;
    bad = 0;
    while (cyc < t0 + F + G + 2) begin
      tick();
      if (cyc == t0 + 5) begin
        req_valid = 4'b0001;
        req_data  = 32'h3C00_005A;
      end
      if (req_ack !== 4'b0000) bad++;
    end
    total++; if (bad !== 0) $display("FAIL late_ack_during_frame got %0d cycles exp 0", bad); else passed++;
    tick();
    total++; if (req_ack !== 4'b0001)  $display("FAIL late_ack got %b exp 0001", req_ack); else passed++;
    total++; if (grant_id !== 2'd0)    $display("FAIL late_grant got %0d exp 0", grant_id); else passed++;
    total++; if (data_out !== 8'h5A)   $display("FAIL late_data got %h exp 5a", data_out); else passed++;
    total++; if (byte_ready !== 1'b1)  $display("FAIL late_byte_ready got %b exp 1", byte_ready); else passed++;
    req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    req_data  = 32'h0088_7700;
    req_valid = 4'b0110;
    tick();
    total++; if (grant_id !== 2'd1)  $display("FAIL midrst_pre_grant got %0d exp 1", grant_id); else passed++;
    total++; if (data_out !== 8'h77) $display("FAIL midrst_pre_data got %h exp 77", data_out); else passed++;
    repeat (7) tick();
    #2;
    rst = 1'b1;
    #1;
    total++; if (req_ack !== 4'b0)    $display("FAIL midrst_ack got %b exp 0000", req_ack); else passed++;
    total++; if (data_out !== 8'h00)  $display("FAIL midrst_data got %h exp 00", data_out); else passed++;
    total++; if (byte_ready !== 1'b0) $display("FAIL midrst_byte_ready got %b exp 0", byte_ready); else passed++;
    total++; if (t_byte !== 1'b0)     $display("FAIL midrst_t_byte got %b exp 0", t_byte); else passed++;
    total++; if (busy !== 1'b0)       $display("FAIL midrst_busy got %b exp 0", busy); else passed++;
    total++; if (grant_id !== 2'd0)   $display("FAIL midrst_grant got %0d exp 0", grant_id); else passed++;
    tick();
    rst = 1'b0;
    tick();
    total++; if (byte_ready !== 1'b1) $display("FAIL midrst_regrant_byte_ready got %b exp 1", byte_ready); else passed++;
    total++; if (grant_id !== 2'd1)   $display("FAIL midrst_regrant_grant got %0d exp 1", grant_id); else passed++;
    total++; if (req_ack !== 4'b0010) $display("FAIL midrst_regrant_ack got %b exp 0010", req_ack); else passed++;
    total++; if (data_out !== 8'h77)  $display("FAIL midrst_regrant_data got %h exp 77", data_out); else passed++;
    req_valid = 4'b0000;
  endtask

  task automatic test_no_guard();
    int t0, per, tb_bad, br_bad, both, pulses;
    logic exp_tb, exp_br;
    do_reset();
    per = F0 + G0 + 2;
    req_data0  = 32'h00C3_0000;
    req_valid0 = 4'b0100;
    t0 = cyc;
    tb_bad = 0; br_bad = 0; both = 0; pulses = 0;
    while (cyc < t0 + 2 + 3 * per) begin
      tick();
      exp_tb = (cyc >= t0 + 2) && ((cyc - t0 - 2) % per == 0);
      exp_br = (cyc >= t0 + 1) && ((cyc - t0 - 1) % per == 0);
      if (t_byte0 !== exp_tb) tb_bad++;
      if (byte_ready0 !== exp_br) br_bad++;
      if (t_byte0 === 1'b1 && byte_ready0 === 1'b1) both++;
      if (t_byte0 === 1'b1) pulses++;
    end
    total++; if (tb_bad !== 0)       $display("FAIL noguard_t_byte_timing got %0d bad cycles exp 0", tb_bad); else passed++;
    total++; if (br_bad !== 0)       $display("FAIL noguard_byte_ready_timing got %0d bad cycles exp 0", br_bad); else passed++;
    total++; if (both !== 0)         $display("FAIL noguard_strobe_overlap got %0d exp 0", both); else passed++;
    total++; if (pulses !== 4)       $display("FAIL noguard_pulses got %0d exp 4", pulses); else passed++;
    total++; if (grant_id0 !== 2'd2) $display("FAIL noguard_grant got %0d exp 2", grant_id0); else passed++;
    total++; if (data_out0 !== 8'hC3) $display("FAIL noguard_data got %h exp c3", data_out0); else passed++;
    req_valid0 = 4'b0000;
  endtask

  task automatic test_drop_pulse();
    int t0, bad;
    do_reset();
    req_data  = 32'h0000_00E1;
    req_valid = 4'b0001;
    t0 = cyc;
    tick();
    total++; if (req_ack !== 4'b0001) $display("FAIL drop_first_ack got %b exp 0001", req_ack); else passed++;
    tick();
    req_valid = 4'b0000;
    bad = 0;
    while (cyc < t0 + F + G + 12) begin
      tick();
      if (cyc == t0 + 5) begin
        req_valid = 4'b0100;
        req_data  = 32'h0099_00E1;
      end else begin
        req_valid = 4'b0000;
      end
      if (req_ack !== 4'b0000 || byte_ready !== 1'b0) bad++;
    end
    total++; if (bad !== 0)           $display("FAIL drop_spurious_grant got %0d cycles exp 0", bad); else passed++;
    total++; if (busy !== 1'b0)       $display("FAIL drop_busy got %b exp 0", busy); else passed++;
    total++; if (data_out !== 8'hE1)  $display("FAIL drop_data_hold got %h exp e1", data_out); else passed++;
  endtask

  // Frame-level model: at each IDLE decision cycle pick the next pending requester after the last
  // winner; the transfer is then visible at +1 (load) and +2 (start), the next decision at +F+G+2.
  task automatic test_random();
    logic [3:0] v, m_ack, exp_ack;
    logic [7:0] d [4];
    int         rel [4];
    logic [7:0] m_data;
    logic [1:0] m_gid;
    int c, next_dec, load_cyc, mptr, w;
    logic exp_br, exp_tb, exp_busy;
    do_reset();
    v = '0; m_ack = '0; m_data = '0; m_gid = '0; mptr = 0;
    for (int i = 0; i < 4; i++) begin d[i] = '0; rel[i] = -1; end
    next_dec = cyc;
    load_cyc = -100;
    for (int n = 0; n < 900; n++) begin
      c = cyc;
      exp_br   = (c == load_cyc);
      exp_tb   = (c == load_cyc + 1);
      exp_ack  = exp_br ? m_ack : 4'b0000;
      exp_busy = (c >= load_cyc) && (c <= load_cyc + F + G);
      total++; if (byte_ready !== exp_br) $display("FAIL rand_byte_ready @%0d got %b exp %b", c, byte_ready, exp_br); else passed++;
      total++; if (t_byte !== exp_tb)     $display("FAIL rand_t_byte @%0d got %b exp %b", c, t_byte, exp_tb); else passed++;
      total++; if (req_ack !== exp_ack)   $display("FAIL rand_ack @%0d got %b exp %b", c, req_ack, exp_ack); else passed++;
      total++; if (busy !== exp_busy)     $display("FAIL rand_busy @%0d got %b exp %b", c, busy, exp_busy); else passed++;
      total++; if (data_out !== m_data)   $display("FAIL rand_data @%0d got %h exp %h", c, data_out, m_data); else passed++;
      total++; if (grant_id !== m_gid)    $display("FAIL rand_grant @%0d got %0d exp %0d", c, grant_id, m_gid); else passed++;
      for (int i = 0; i < 4; i++) begin
        if (v[i] && rel[i] == c) begin
          v[i] = 1'b0;
        end else if (!v[i] && rel[i] < c && $urandom_range(0, 7) == 0) begin
          v[i] = 1'b1;
          d[i] = 8'($urandom);
        end
      end
      req_valid = v;
      req_data  = {d[3], d[2], d[1], d[0]};
      if (c == next_dec) begin
        if (|v) begin
          w = -1;
          for (int j = 0; j < 4; j++) begin
            if (w < 0 && v[(mptr + j) % 4]) w = (mptr + j) % 4;
          end
          m_data   = d[w];
          m_gid    = 2'(w);
          m_ack    = 4'b0001 << w;
          rel[w]   = c + 2;
          mptr     = (w + 1) % 4;
          load_cyc = c + 1;
          next_dec = c + F + G + 2;
        end else begin
          next_dec = c + 1;
        end
      end
      tick();
    end
    req_valid = 4'b0000;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_data = '0; req_valid0 = '0; req_data0 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_late_request();
    test_reset_mid_wait();
    test_no_guard();
    test_drop_pulse();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
